spi_wavegen_core: RTL and testbench

- Command-decoded waveform generator between the SPI slave word receiver and the AD9744 DAC data bus.
- Accepts framed 32-bit command words and writes waveform samples into an internal table.
- Plays the table back through a phase accumulator (DDS) at a programmable rate, with enable/disable and a programmable idle code.
- Parametrised successor of the fixed 256 x 14-bit sine playback path.

---
 rtl/wavegen_pkg.sv | 30 +++
 rtl/spi_wavegen_core_if.sv | 25 ++
 rtl/spi_wavegen_core_ram.sv | 26 ++
 rtl/spi_wavegen_core.sv | 146 ++++++++++++++
 tb/tb_spi_wavegen_core.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared constants for the SPI-fed waveform generator: widths, derived
// command-word field positions, opcodes and the playback state type.
package wavegen_pkg;

  localparam int WORD_W = 32;  // received command word width
  localparam int CMD_W  = 4;   // opcode width (top bits of the word)
  localparam int DATA_W = 14;  // sample width (DAC resolution)
  localparam int ADDR_W = 8;   // table address width
  localparam int ACC_W  = 32;  // phase accumulator width

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int PAYLOAD_W = WORD_W - CMD_W;     // bits below the opcode
  localparam int AFIELD_W  = PAYLOAD_W - DATA_W; // address field above the data

  localparam logic [ACC_W-1:0]  INC_DEFAULT  = 32'h0100_0000;
  localparam logic [DATA_W-1:0] IDLE_DEFAULT = 14'h2000;

  localparam logic [CMD_W-1:0] OP_NOP      = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_WRITE    = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_ENABLE   = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_DISABLE  = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_SET_INC  = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_SET_IDLE = CMD_W'(5);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

endpackage

// File: rtl/spi_wavegen_core_if.sv
// Word-receiver side and DAC side of the waveform generator, bundled.
// master = word source / DAC consumer, slave = the generator core.
interface spi_wavegen_core_if;
  import wavegen_pkg::*;

  logic              rx_valid;
  logic [WORD_W-1:0] rx_data;
  logic [DATA_W-1:0] wd;
  logic              wd_valid;
  logic              running;
  logic              cmd_err;
  logic [7:0]        cmd_count;
  logic [ACC_W-1:0]  phase;

  modport master (
    output rx_valid, rx_data,
    input  wd, wd_valid, running, cmd_err, cmd_count, phase
  );

  modport slave (
    input  rx_valid, rx_data,
    output wd, wd_valid, running, cmd_err, cmd_count, phase
  );

endinterface

// File: rtl/spi_wavegen_core_ram.sv
// Waveform table: simple dual-port RAM, one write port and one registered
// read port with read-first behaviour on an address collision.
module wave_ram #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Write on request; read every cycle into the output register.
  // NOTE: no reset here, so the array maps onto block RAM and the table
  // survives a reset. Non-blocking assignments make the read see the
  // pre-write contents, which is exactly the read-first collision rule.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/spi_wavegen_core.sv
// Command-decoded DDS waveform generator: decodes framed words into table
// writes and control, accumulates phase, reads the table and registers the
// DAC sample. Pipeline: phase -> RAM read -> wd register.
module spi_wavegen_core
  import wavegen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  spi_wavegen_core_if.slave  bus
);

  run_state_e r_state, w_state_nxt;

  logic [CMD_W-1:0]     w_cmd;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [DATA_W-1:0]    w_data;
  logic [AFIELD_W-1:0]  w_afield;
  logic                 w_addr_ok;
  logic                 w_we, w_accept, w_err, w_phase_clr, w_inc_ld, w_idle_ld;
  logic                 w_running;

  logic [ACC_W-1:0]  r_phase, r_inc;
  logic [DATA_W-1:0] r_idle, r_wd, w_rd_data;
  logic              r_rd_valid, r_wd_valid, r_cmd_err;
  logic [7:0]        r_cmd_count;

  assign w_cmd     = bus.rx_data[WORD_W-1 -: CMD_W];
  assign w_payload = bus.rx_data[PAYLOAD_W-1:0];
  assign w_data    = w_payload[DATA_W-1:0];
  assign w_afield  = w_payload[DATA_W +: AFIELD_W];
  assign w_addr_ok = (w_afield >> ADDR_W) == '0;
  assign w_running = (r_state == ST_RUNNING);

  // Playback state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_STOPPED;
    else     r_state <= w_state_nxt;
  end

  // Command decode: next playback state plus one-cycle action strobes.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_phase_clr = 1'b0;
    w_inc_ld    = 1'b0;
    w_idle_ld   = 1'b0;
    if (bus.rx_valid) begin
      case (w_cmd)
        OP_NOP:      w_accept = 1'b1;
        OP_WRITE: begin
          if (w_addr_ok) begin
            w_we     = 1'b1;
            w_accept = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        OP_ENABLE: begin
          w_state_nxt = ST_RUNNING;
          w_phase_clr = 1'b1;
          w_accept    = 1'b1;
        end
        OP_DISABLE: begin
          w_state_nxt = ST_STOPPED;
          w_accept    = 1'b1;
        end
        OP_SET_INC: begin
          w_inc_ld = 1'b1;
          w_accept = 1'b1;
        end
        OP_SET_IDLE: begin
          w_idle_ld = 1'b1;
          w_accept  = 1'b1;
        end
        default:     w_err = 1'b1;
      endcase
    end
  end

  // Configuration registers, sticky error flag and accepted-command counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inc       <= INC_DEFAULT;
      r_idle      <= IDLE_DEFAULT;
      r_cmd_err   <= 1'b0;
      r_cmd_count <= '0;
    end else begin
      if (w_inc_ld)  r_inc       <= ACC_W'(w_payload);
      if (w_idle_ld) r_idle      <= w_data;
      if (w_err)     r_cmd_err   <= 1'b1;
      if (w_accept)  r_cmd_count <= r_cmd_count + 8'd1;
    end
  end

  // Stage 0: phase accumulator, restarted by ENABLE, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)              r_phase <= '0;
    else if (w_phase_clr) r_phase <= '0;
    else if (w_running)   r_phase <= r_phase + r_inc;
  end

  // Stage 1: table lookup on the top phase bits; writes are masked in reset.
  wave_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we & ~rst),
    .i_waddr (w_afield[ADDR_W-1:0]),
    .i_wdata (w_data),
    .i_raddr (r_phase[ACC_W-1 -: ADDR_W]),
    .o_rdata (w_rd_data)
  );

  // Tracks whether the RAM output register holds a playback sample.
  always_ff @(posedge clk) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= w_running;
  end

  // Stage 2: DAC register; a stop drops the in-flight sample immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd       <= IDLE_DEFAULT;
      r_wd_valid <= 1'b0;
    end else if (w_running && r_rd_valid) begin
      r_wd       <= w_rd_data;
      r_wd_valid <= 1'b1;
    end else begin
      r_wd       <= r_idle;
      r_wd_valid <= 1'b0;
    end
  end

  assign bus.wd        = r_wd;
  assign bus.wd_valid  = r_wd_valid;
  assign bus.running   = w_running;
  assign bus.cmd_err   = r_cmd_err;
  assign bus.cmd_count = r_cmd_count;
  assign bus.phase     = r_phase;

endmodule

// File: tb/tb_spi_wavegen_core.sv
// Directed bench for spi_wavegen_core: ramp playback, rate change, stop and
// idle code, error handling, read-first collision, reset mid-run, zero step.
module tb_spi_wavegen_core;
  import wavegen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  spi_wavegen_core_if bus ();

  spi_wavegen_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [13:0] a,
                                     input logic [13:0] d);
    return {c, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one decode edge.
  task automatic send(input logic [31:0] w);
    bus.rx_valid = 1'b1;
    bus.rx_data  = w;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.wd !== 14'h2000) begin n_mis++; $display("FAIL reset_wd: got %h want 2000", bus.wd); end
    n_cmp++; if (bus.wd_valid !== 1'b0) begin n_mis++; $display("FAIL reset_wd_valid: got %b want 0", bus.wd_valid); end
    n_cmp++; if (bus.running !== 1'b0) begin n_mis++; $display("FAIL reset_running: got %b want 0", bus.running); end
    n_cmp++; if (bus.cmd_err !== 1'b0) begin n_mis++; $display("FAIL reset_cmd_err: got %b want 0", bus.cmd_err); end
    n_cmp++; if (bus.cmd_count !== 8'd0) begin n_mis++; $display("FAIL reset_cmd_count: got %0d want 0", bus.cmd_count); end
    n_cmp++; if (bus.phase !== 32'd0) begin n_mis++; $display("FAIL reset_phase: got %h want 0", bus.phase); end
    rst = 1'b0;
  endtask

  // table[i] = i*64, back-to-back writes, then one sample per clock.
  task automatic test_ramp();
    logic [13:0] exp;
    for (int i = 0; i < 256; i++) send(mk(OP_WRITE, 14'(i), 14'(i * 64)));
    n_cmp++; if (bus.cmd_count !== 8'd0) begin n_mis++; $display("FAIL ramp_count_wrap: got %0d want 0", bus.cmd_count); end
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    n_cmp++; if (bus.running !== 1'b1) begin n_mis++; $display("FAIL ramp_running: got %b want 1", bus.running); end
    n_cmp++; if (bus.phase !== 32'd0) begin n_mis++; $display("FAIL ramp_phase0: got %h want 0", bus.phase); end
    n_cmp++; if (bus.cmd_count !== 8'd1) begin n_mis++; $display("FAIL ramp_count_enable: got %0d want 1", bus.cmd_count); end
    tick();
    n_cmp++; if (bus.phase !== 32'h0100_0000) begin n_mis++; $display("FAIL ramp_phase1: got %h want 01000000", bus.phase); end
    for (int k = 0; k < 258; k++) begin
      tick();
      exp = 14'((k % 256) * 64);
      n_cmp++; if (bus.wd !== exp || bus.wd_valid !== 1'b1) begin
        n_mis++; $display("FAIL ramp_sample[%0d]: got %0d/%b want %0d/1", k, bus.wd, bus.wd_valid, exp);
      end
    end
  endtask

  // Half-rate playback, then double rate applied one accumulation later.
  task automatic test_set_inc();
    int post_idx [5] = '{5, 5, 7, 9, 11};
    logic [13:0] exp;
    post_idx[0] = 4;
    send(mk(OP_DISABLE, 14'd0, 14'd0));
    send({OP_SET_INC, 28'h080_0000});
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j >= 2) begin
        exp = 14'(64 * ((j - 2) / 2));
        n_cmp++; if (bus.wd !== exp) begin n_mis++; $display("FAIL inc_half[%0d]: got %0d want %0d", j, bus.wd, exp); end
      end
    end
    send({OP_SET_INC, 28'h200_0000});
    n_cmp++; if (bus.wd !== 14'd256) begin n_mis++; $display("FAIL inc_cmd_edge: got %0d want 256", bus.wd); end
    for (int j = 0; j < 5; j++) begin
      tick();
      exp = 14'(64 * post_idx[j]);
      n_cmp++; if (bus.wd !== exp) begin n_mis++; $display("FAIL inc_double[%0d]: got %0d want %0d", j, bus.wd, exp); end
    end
  endtask

  task automatic test_disable();
    send(mk(OP_DISABLE, 14'd0, 14'd0));
    n_cmp++; if (bus.running !== 1'b0) begin n_mis++; $display("FAIL dis_running: got %b want 0", bus.running); end
    tick();
    n_cmp++; if (bus.wd !== 14'h2000 || bus.wd_valid !== 1'b0) begin
      n_mis++; $display("FAIL dis_idle: got %h/%b want 2000/0", bus.wd, bus.wd_valid);
    end
    send(mk(OP_SET_IDLE, 14'd0, 14'h0000));
    n_cmp++; if (bus.wd !== 14'h2000) begin n_mis++; $display("FAIL idle_cmd_edge: got %h want 2000", bus.wd); end
    tick();
    n_cmp++; if (bus.wd !== 14'h0000) begin n_mis++; $display("FAIL idle_new: got %h want 0000", bus.wd); end
  endtask

  // Count so far: 1 after ramp, +4 in set_inc, +2 in disable = 7.
  task automatic test_errors();
    n_cmp++; if (bus.cmd_err !== 1'b0) begin n_mis++; $display("FAIL err_pre: got %b want 0", bus.cmd_err); end
    send(mk(OP_WRITE, 14'd300, 14'h1234));
    n_cmp++; if (bus.cmd_err !== 1'b1) begin n_mis++; $display("FAIL err_addr: got %b want 1", bus.cmd_err); end
    n_cmp++; if (bus.cmd_count !== 8'd7) begin n_mis++; $display("FAIL err_addr_count: got %0d want 7", bus.cmd_count); end
    send(mk(4'd9, 14'd45, 14'h0555));
    n_cmp++; if (bus.cmd_count !== 8'd7) begin n_mis++; $display("FAIL err_op_count: got %0d want 7", bus.cmd_count); end
    send({OP_SET_INC, 28'h100_0000});
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    n_cmp++; if (bus.cmd_count !== 8'd9 || bus.cmd_err !== 1'b1) begin
      n_mis++; $display("FAIL err_sticky: got %0d/%b want 9/1", bus.cmd_count, bus.cmd_err);
    end
    for (int k = 1; k <= 47; k++) begin
      tick();
      if (k == 2) begin
        n_cmp++; if (bus.wd_valid !== 1'b1) begin n_mis++; $display("FAIL err_valid: got %b want 1", bus.wd_valid); end
      end
      if (k == 46) begin
        n_cmp++; if (bus.wd !== 14'd2816) begin n_mis++; $display("FAIL err_tbl44: got %0d want 2816", bus.wd); end
      end
      if (k == 47) begin
        n_cmp++; if (bus.wd !== 14'd2880) begin n_mis++; $display("FAIL err_tbl45: got %0d want 2880", bus.wd); end
      end
    end
  endtask

  // ENABLE while running restarts; table[5] is rewritten on the edge it is read.
  task automatic test_read_first();
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 2) begin
        n_cmp++; if (bus.wd !== 14'd0 || bus.wd_valid !== 1'b1) begin
          n_mis++; $display("FAIL rf_restart: got %0d/%b want 0/1", bus.wd, bus.wd_valid);
        end
      end
      if (j == 5) begin
        n_cmp++; if (bus.wd !== 14'd192) begin n_mis++; $display("FAIL rf_idx3: got %0d want 192", bus.wd); end
      end
    end
    send(mk(OP_WRITE, 14'd5, 14'h3FFF));
    tick();
    n_cmp++; if (bus.wd !== 14'd320) begin n_mis++; $display("FAIL rf_old: got %0d want 320", bus.wd); end
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) begin
        n_cmp++; if (bus.wd !== 14'd256) begin n_mis++; $display("FAIL rf_idx4: got %0d want 256", bus.wd); end
      end
      if (k == 256) begin
        n_cmp++; if (bus.wd !== 14'h3FFF) begin n_mis++; $display("FAIL rf_new: got %h want 3fff", bus.wd); end
      end
    end
  endtask

  // One-cycle reset mid-playback with a WRITE presented that must be ignored.
  task automatic test_reset_mid();
    rst          = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = mk(OP_WRITE, 14'd10, 14'h0AAA);
    tick();
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    n_cmp++; if (bus.wd !== 14'h2000 || bus.wd_valid !== 1'b0 || bus.running !== 1'b0) begin
      n_mis++; $display("FAIL rstmid_out: got %h/%b/%b want 2000/0/0", bus.wd, bus.wd_valid, bus.running);
    end
    n_cmp++; if (bus.cmd_err !== 1'b0 || bus.cmd_count !== 8'd0 || bus.phase !== 32'd0) begin
      n_mis++; $display("FAIL rstmid_regs: got %b/%0d/%h want 0/0/0", bus.cmd_err, bus.cmd_count, bus.phase);
    end
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    n_cmp++; if (bus.cmd_count !== 8'd1) begin n_mis++; $display("FAIL rstmid_count: got %0d want 1", bus.cmd_count); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) begin
        n_cmp++; if (bus.wd !== 14'd0 || bus.wd_valid !== 1'b1) begin
          n_mis++; $display("FAIL rstmid_t0: got %0d/%b want 0/1", bus.wd, bus.wd_valid);
        end
      end
      if (k == 7) begin
        n_cmp++; if (bus.wd !== 14'h3FFF) begin n_mis++; $display("FAIL rstmid_t5: got %h want 3fff", bus.wd); end
      end
      if (k == 12) begin
        n_cmp++; if (bus.wd !== 14'd640) begin n_mis++; $display("FAIL rstmid_t10: got %0d want 640", bus.wd); end
      end
    end
  endtask

  task automatic test_zero_inc();
    send({OP_SET_INC, 28'h000_0000});
    send(mk(OP_ENABLE, 14'd0, 14'd0));
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 2) begin
        n_cmp++; if (bus.wd !== 14'd0 || bus.wd_valid !== 1'b1 || bus.phase !== 32'd0) begin
          n_mis++; $display("FAIL zero_inc[%0d]: got %0d/%b/%h want 0/1/0", k, bus.wd, bus.wd_valid, bus.phase);
        end
      end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_ramp();
    test_set_inc();
    test_disable();
    test_errors();
    test_read_first();
    test_reset_mid();
    test_zero_inc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
